lsu_mem_stage: RTL

- Load/store unit for the MEM stage of the pipelined MIPS core; consumes the effective address computed in EX for base+offset accesses.
- Checks alignment and drives a req/ack data-memory port with word address, byte enables and lane-replicated store data.
- Returns sign- or zero-extended load data to write-back and stalls the pipeline while an access is outstanding.

---
 rtl/lsu_mem_stage_pkg.sv | 34 +++
 rtl/lsu_load_align.sv | 37 +++
 rtl/lsu_mem_stage.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_stage_pkg.sv
// Shared definitions for the MEM-stage load/store unit: access size codes, FSM states,
// default bus timeout and the alignment / byte-enable helpers used by the request path.
package lsu_mem_stage_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b11;

   localparam int TIMEOUT_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   // Size code 2'b10 falls into the word branch in both helpers.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return lane[0];
         default: return |lane;
      endcase
   endfunction

   function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         SZ_BYTE: return 4'b0001 << lane;
         SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load formatting: picks the addressed byte/half lane of a little-endian read word and
// sign- or zero-extends it. Purely combinational, no flow control.
module lsu_load_align
   import lsu_mem_stage_pkg::*;
#(
   parameter int NB_DATA = 32
) (
   input  logic [NB_DATA-1:0] i_rdata,
   input  logic [1:0]         i_lane,
   input  logic [1:0]         i_size,
   input  logic               i_unsigned,
   output logic [NB_DATA-1:0] o_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic        sign_bit;

   always_comb begin
      byte_sel = i_rdata[{i_lane, 3'b000} +: 8];
      half_sel = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
      sign_bit = 1'b0;
      o_data   = i_rdata;
      case (i_size)
         SZ_BYTE: begin
            sign_bit = byte_sel[7] & ~i_unsigned;
            o_data   = {{(NB_DATA-8){sign_bit}}, byte_sel};
         end
         SZ_HALF: begin
            sign_bit = half_sel[15] & ~i_unsigned;
            o_data   = {{(NB_DATA-16){sign_bit}}, half_sel};
         end
         default: o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: aligned ops issue one req/ack access (load result 2 cycles after accept at best),
// misaligned ops raise o_addr_exc; o_stall holds the pipeline from accept until the access retires.
module lsu_mem_stage
   import lsu_mem_stage_pkg::*;
#(
   parameter int NB_DATA = 32,
   parameter int NB_REG  = 5,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_valid,
   input  logic               i_mem_read,
   input  logic               i_mem_write,
   input  logic [1:0]         i_size,
   input  logic               i_unsigned,
   input  logic [NB_DATA-1:0] i_eff_addr,
   input  logic [NB_DATA-1:0] i_store_data,
   input  logic [NB_REG-1:0]  i_rd,
   output logic               o_mem_req,
   output logic               o_mem_we,
   output logic [NB_DATA-1:0] o_mem_addr,
   output logic [3:0]         o_mem_be,
   output logic [NB_DATA-1:0] o_mem_wdata,
   input  logic               i_mem_ack,
   input  logic [NB_DATA-1:0] i_mem_rdata,
   output logic               o_stall,
   output logic               o_load_valid,
   output logic [NB_DATA-1:0] o_load_data,
   output logic [NB_REG-1:0]  o_load_rd,
   output logic               o_addr_exc,
   output logic               o_bus_err,
   output logic [NB_DATA-1:0] o_exc_addr
);

   localparam int CNT_W = $clog2(TIMEOUT);

   typedef struct packed {
      logic [NB_DATA-1:0] addr;
      logic [1:0]         size;
      logic               uns;
      logic [NB_REG-1:0]  rd;
      logic               we;
      logic [3:0]         be;
      logic [NB_DATA-1:0] wdata;
   } acc_t;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   acc_t               acc_q, acc_d;
   logic [NB_DATA-1:0] load_data_q, load_data_d;
   logic               addr_exc_q, addr_exc_d;
   logic               bus_err_q, bus_err_d;
   logic [NB_DATA-1:0] exc_addr_q, exc_addr_d;

   logic               accept;
   logic               misaligned;
   logic [NB_DATA-1:0] fmt_data;

   lsu_load_align #(
      .NB_DATA (NB_DATA)
   ) u_load_align (
      .i_rdata    (i_mem_rdata),
      .i_lane     (acc_q.addr[1:0]),
      .i_size     (acc_q.size),
      .i_unsigned (acc_q.uns),
      .o_data     (fmt_data)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      load_data_d = load_data_q;
      addr_exc_d  = 1'b0;
      bus_err_d   = 1'b0;
      exc_addr_d  = exc_addr_q;
      o_stall     = 1'b0;
      accept      = i_valid & (i_mem_read | i_mem_write) & ~i_reset;
      misaligned  = is_misaligned(i_size, i_eff_addr[1:0]);

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (accept && misaligned) begin
               addr_exc_d = 1'b1;
               exc_addr_d = i_eff_addr;
            end else if (accept) begin
               acc_d.addr = i_eff_addr;
               acc_d.size = i_size;
               acc_d.uns  = i_unsigned;
               acc_d.rd   = i_rd;
               acc_d.we   = i_mem_write;
               acc_d.be   = byte_enables(i_size, i_eff_addr[1:0]);
               case (i_size)
                  SZ_BYTE: acc_d.wdata = {(NB_DATA/8){i_store_data[7:0]}};
                  SZ_HALF: acc_d.wdata = {(NB_DATA/16){i_store_data[15:0]}};
                  default: acc_d.wdata = i_store_data;
               endcase
               o_stall = 1'b1;
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            o_stall = 1'b1;
            // Ack is tested first so an ack on the last timeout cycle still completes normally.
            if (i_mem_ack) begin
               cnt_d = '0;
               if (acc_q.we) begin
                  state_d = ST_IDLE;
               end else begin
                  load_data_d = fmt_data;
                  state_d     = ST_RESP;
               end
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               cnt_d      = '0;
               bus_err_d  = 1'b1;
               exc_addr_d = acc_q.addr;
               state_d    = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RESP: begin
            o_stall = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         load_data_q <= '0;
         addr_exc_q  <= 1'b0;
         bus_err_q   <= 1'b0;
         exc_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         load_data_q <= load_data_d;
         addr_exc_q  <= addr_exc_d;
         bus_err_q   <= bus_err_d;
         exc_addr_q  <= exc_addr_d;
      end
   end

   // Bus fields are forced to zero whenever no request is outstanding.
   always_comb begin
      o_mem_req    = (state_q == ST_ACCESS);
      o_mem_we     = o_mem_req & acc_q.we;
      o_mem_addr   = o_mem_req ? {acc_q.addr[NB_DATA-1:2], 2'b00} : '0;
      o_mem_be     = o_mem_req ? acc_q.be : 4'b0000;
      o_mem_wdata  = o_mem_req ? acc_q.wdata : '0;
      o_load_valid = (state_q == ST_RESP);
      o_load_data  = o_load_valid ? load_data_q : '0;
      o_load_rd    = o_load_valid ? acc_q.rd : '0;
      o_addr_exc   = addr_exc_q;
      o_bus_err    = bus_err_q;
      o_exc_addr   = exc_addr_q;
   end

endmodule
